// File: rtl/pic_pkg.sv
// Shared encodings for the 8259A control/priority stage: read-select codes,
// OCW2 EOI command codes, and the init and INTA sequencer state types.
package pic_pkg;

  localparam logic [1:0] RD_IRR = 2'b10;
  localparam logic [1:0] RD_ISR = 2'b11;

  localparam logic [2:0] NS_EOI = 3'b001;
  localparam logic [2:0] SP_EOI = 3'b011;

  typedef enum logic [2:0] {
    UNINIT,
    WAIT_ICW2,
    WAIT_ICW3,
    WAIT_ICW4,
    READY
  } init_state_t;

  typedef enum logic [1:0] {
    IDLE,
    ACK1,
    WAIT2,
    ACK2
  } inta_state_t;

endpackage

// File: rtl/pic_priority_resolver.sv
// Fixed-priority resolver: reports the lowest set bit index of vec (bit 0 wins)
// and whether any bit is set at all.
module pic_priority_resolver #(
  parameter int W     = 8,
  parameter int IDX_W = $clog2(W)
) (
  input  logic [W-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             vld
);

  // Scan downwards so the lowest set index is the last one written
  always_comb begin
    idx = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

  assign vld = |vec;

endmodule

// File: rtl/pic_control_logic.sv
// 8259A control/priority stage: ICW/OCW programming, fixed-priority INT
// generation and the two-pulse 8086-mode INTA sequence with vector return.
module pic_control_logic
  import pic_pkg::*;
#(
  parameter int VEC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       ICW,
  input  logic [2:0]       OCW,
  input  logic [VEC_W-1:0] D,
  input  logic [VEC_W-1:0] IRR,
  input  logic             INTA_n,
  output logic             INT,
  output logic [VEC_W-1:0] Interrupt_Vector,
  output logic             IV_ready,
  output logic [VEC_W-1:0] ISR,
  output logic [VEC_W-1:0] IMR,
  output logic [1:0]       Read_command
);

  localparam int IDX_W = $clog2(VEC_W);
  localparam int T_W   = VEC_W - IDX_W;

  logic [3:0]       icw_p1;
  logic [2:0]       ocw_p1;
  logic             inta_n_p1;
  logic [3:0]       icw_rise;
  logic [2:0]       ocw_rise;
  logic [2:0]       ocw_ok;
  logic             inta_fall;
  logic             inta_rise;

  logic [T_W-1:0]   t_q;
  logic             sngl_q;
  logic             ic4_q;
  logic             aeoi_q;
  logic [IDX_W-1:0] lvl_q;
  logic             spur_q;

  init_state_t      init_st, init_nxt;
  inta_state_t      inta_st, inta_nxt;

  logic [VEC_W-1:0] pend;
  logic [IDX_W-1:0] pend_idx;
  logic             pend_vld;
  logic [IDX_W-1:0] isr_idx;
  logic             isr_vld;
  logic [VEC_W-1:0] isr_set;
  logic [VEC_W-1:0] isr_clr;
  logic [2:0]       ocw2_code;

  assign icw_rise  = ICW & ~icw_p1;
  assign ocw_rise  = OCW & ~ocw_p1;
  assign ocw_ok    = (init_st == READY) ? ocw_rise : 3'b000;
  assign inta_fall = inta_n_p1 & ~INTA_n;
  assign inta_rise = ~inta_n_p1 & INTA_n;
  assign ocw2_code = D[VEC_W-1 -: 3];
  assign pend      = IRR & ~IMR;

  pic_priority_resolver #(.W(VEC_W), .IDX_W(IDX_W)) u_pend_res (
    .vec (pend),
    .idx (pend_idx),
    .vld (pend_vld)
  );

  pic_priority_resolver #(.W(VEC_W), .IDX_W(IDX_W)) u_isr_res (
    .vec (ISR),
    .idx (isr_idx),
    .vld (isr_vld)
  );

  // Initialisation sequencer; ICW1 restarts it from any state
  always_comb begin
    init_nxt = init_st;
    if (icw_rise[0]) begin
      init_nxt = WAIT_ICW2;
    end else begin
      case (init_st)
        WAIT_ICW2: if (icw_rise[1]) init_nxt = !sngl_q ? WAIT_ICW3 :
                                               (ic4_q ? WAIT_ICW4 : READY);
        WAIT_ICW3: if (icw_rise[2]) init_nxt = ic4_q ? WAIT_ICW4 : READY;
        WAIT_ICW4: if (icw_rise[3]) init_nxt = READY;
        default:   init_nxt = init_st;
      endcase
    end
  end

  always_comb begin
    inta_nxt = inta_st;
    if (icw_rise[0]) begin
      inta_nxt = IDLE;
    end else begin
      case (inta_st)
        IDLE:    if (inta_fall) inta_nxt = ACK1;
        ACK1:    if (INTA_n)    inta_nxt = WAIT2;
        WAIT2:   if (inta_fall) inta_nxt = ACK2;
        ACK2:    if (inta_rise) inta_nxt = IDLE;
        default: inta_nxt = IDLE;
      endcase
    end
  end

  // All ISR set/clear sources merge here; a clear beats a set on the same bit
  always_comb begin
    isr_set = '0;
    isr_clr = '0;
    if (inta_st == IDLE && inta_fall && pend_vld)
      isr_set = VEC_W'(1) << pend_idx;
    if (ocw_ok[1]) begin
      if (ocw2_code == NS_EOI && isr_vld)
        isr_clr = isr_clr | (VEC_W'(1) << isr_idx);
      else if (ocw2_code == SP_EOI)
        isr_clr = isr_clr | (VEC_W'(1) << D[IDX_W-1:0]);
    end
    if (inta_st == ACK2 && inta_rise && aeoi_q && !spur_q)
      isr_clr = isr_clr | (VEC_W'(1) << lvl_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      init_st <= UNINIT;
      inta_st <= IDLE;
    end else begin
      init_st <= init_nxt;
      inta_st <= inta_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      icw_p1    <= '0;
      ocw_p1    <= '0;
      inta_n_p1 <= 1'b1;
    end else begin
      icw_p1    <= ICW;
      ocw_p1    <= OCW;
      inta_n_p1 <= INTA_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      t_q          <= '0;
      sngl_q       <= 1'b1;
      ic4_q        <= 1'b0;
      aeoi_q       <= 1'b0;
      IMR          <= '0;
      ISR          <= '0;
      Read_command <= RD_IRR;
    end else if (icw_rise[0]) begin
      sngl_q       <= D[1];
      ic4_q        <= D[0];
      aeoi_q       <= 1'b0;
      IMR          <= '0;
      ISR          <= '0;
      Read_command <= RD_IRR;
    end else begin
      if (icw_rise[1] && init_st == WAIT_ICW2) t_q <= D[VEC_W-1:IDX_W];
      if (icw_rise[3] && init_st == WAIT_ICW4) aeoi_q <= D[1];
      if (ocw_ok[0]) IMR <= D;
      if (ocw_ok[2] && D[1]) Read_command <= {1'b1, D[0]};
      ISR <= (ISR | isr_set) & ~isr_clr;
    end
  end

  // Acknowledge datapath: level frozen on the first pulse, vector on the second
  always_ff @(posedge clk) begin
    if (rst) begin
      lvl_q            <= '0;
      spur_q           <= 1'b0;
      IV_ready         <= 1'b0;
      Interrupt_Vector <= '0;
      INT              <= 1'b0;
    end else begin
      if (inta_st == IDLE && inta_fall && !icw_rise[0]) begin
        lvl_q  <= pend_vld ? pend_idx : '1;
        spur_q <= ~pend_vld;
      end
      if (icw_rise[0]) begin
        IV_ready <= 1'b0;
      end else if (inta_st == WAIT2 && inta_fall) begin
        IV_ready         <= 1'b1;
        Interrupt_Vector <= {t_q, lvl_q};
      end else if (inta_st == ACK2 && inta_rise) begin
        IV_ready <= 1'b0;
      end
      INT <= (init_nxt == READY) && (inta_nxt == IDLE) && pend_vld &&
             (!isr_vld || (pend_idx < isr_idx));
    end
  end

endmodule

// File: tb/tb_pic_control_logic.sv
// Directed bench for pic_control_logic: init sequence, priority, INTA cycles,
// EOI/AEOI, spurious requests, OCW3 read select, ICW1 abort and reset.
module tb_pic_control_logic;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] ICW;
  logic [2:0] OCW;
  logic [7:0] D;
  logic [7:0] IRR;
  logic       INTA_n;
  logic       INT;
  logic [7:0] Interrupt_Vector;
  logic       IV_ready;
  logic [7:0] ISR;
  logic [7:0] IMR;
  logic [1:0] Read_command;

  int n_cmp  = 0;
  int n_fail = 0;

  pic_control_logic #(.VEC_W(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .ICW              (ICW),
    .OCW              (OCW),
    .D                (D),
    .IRR              (IRR),
    .INTA_n           (INTA_n),
    .INT              (INT),
    .Interrupt_Vector (Interrupt_Vector),
    .IV_ready         (IV_ready),
    .ISR              (ISR),
    .IMR              (IMR),
    .Read_command     (Read_command)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_icw(input int n, input logic [7:0] d);
    ICW = 4'(1 << n);
    D   = d;
    step();
    ICW = 4'b0;
    step();
  endtask

  task automatic wr_ocw(input int n, input logic [7:0] d);
    OCW = 3'(1 << n);
    D   = d;
    step();
    OCW = 3'b0;
    step();
  endtask

  task automatic inta_cycle();
    INTA_n = 1'b0; step();
    INTA_n = 1'b1; step();
    INTA_n = 1'b0; step();
    INTA_n = 1'b1; step();
  endtask

  task automatic test_reset();
    rst = 1'b1; ICW = 4'b0; OCW = 3'b0; D = 8'h00; IRR = 8'h00; INTA_n = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
    n_cmp++; if (INT !== 1'b0) begin n_fail++; $display("FAIL reset_int got %b want 0", INT); end
    n_cmp++; if (Interrupt_Vector !== 8'h00) begin n_fail++; $display("FAIL reset_vec got %h want 00", Interrupt_Vector); end
    n_cmp++; if (IV_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ivr got %b want 0", IV_ready); end
    n_cmp++; if (ISR !== 8'h00) begin n_fail++; $display("FAIL reset_isr got %h want 00", ISR); end
    n_cmp++; if (IMR !== 8'h00) begin n_fail++; $display("FAIL reset_imr got %h want 00", IMR); end
    n_cmp++; if (Read_command !== 2'b10) begin n_fail++; $display("FAIL reset_rdcmd got %b want 10", Read_command); end
  endtask

  task automatic test_init();
    wr_icw(0, 8'h13);
    wr_ocw(0, 8'hFF);
    n_cmp++; if (IMR !== 8'h00) begin n_fail++; $display("FAIL ocw_before_ready got %h want 00", IMR); end
    wr_icw(1, 8'h40);
    wr_icw(3, 8'h01);
  endtask

  task automatic test_basic();
    IRR = 8'h24; step();
    n_cmp++; if (INT !== 1'b1) begin n_fail++; $display("FAIL basic_int got %b want 1", INT); end
    INTA_n = 1'b0; step();
    n_cmp++; if (ISR !== 8'h04) begin n_fail++; $display("FAIL basic_isr_set got %h want 04", ISR); end
    n_cmp++; if (INT !== 1'b0) begin n_fail++; $display("FAIL basic_int_ack got %b want 0", INT); end
    IRR = 8'h01; INTA_n = 1'b1; step();
    INTA_n = 1'b0; step();
    n_cmp++; if (IV_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ivr got %b want 1", IV_ready); end
    n_cmp++; if (Interrupt_Vector !== 8'h42) begin n_fail++; $display("FAIL basic_vec_frozen got %h want 42", Interrupt_Vector); end
    INTA_n = 1'b1; step();
    n_cmp++; if (IV_ready !== 1'b0) begin n_fail++; $display("FAIL basic_ivr_end got %b want 0", IV_ready); end
    IRR = 8'h24; step();
    n_cmp++; if (INT !== 1'b0) begin n_fail++; $display("FAIL basic_int_same_lvl got %b want 0", INT); end
    wr_ocw(1, 8'h20);
    n_cmp++; if (ISR !== 8'h00) begin n_fail++; $display("FAIL basic_ns_eoi got %h want 00", ISR); end
    IRR = 8'h00; step();
  endtask

  task automatic test_preempt();
    IRR = 8'h04; step();
    inta_cycle();
    n_cmp++; if (ISR !== 8'h04) begin n_fail++; $display("FAIL pre_isr got %h want 04", ISR); end
    IRR = 8'h09; step();
    n_cmp++; if (INT !== 1'b1) begin n_fail++; $display("FAIL pre_ir0 got %b want 1", INT); end
    IRR = 8'h08; step();
    n_cmp++; if (INT !== 1'b0) begin n_fail++; $display("FAIL pre_ir3 got %b want 0", INT); end
    IRR = 8'h09;
    wr_ocw(0, 8'h01);
    n_cmp++; if (IMR !== 8'h01) begin n_fail++; $display("FAIL pre_imr got %h want 01", IMR); end
    n_cmp++; if (INT !== 1'b0) begin n_fail++; $display("FAIL pre_masked got %b want 0", INT); end
    IRR = 8'h00;
    wr_ocw(0, 8'h00);
    wr_ocw(1, 8'h62);
    n_cmp++; if (ISR !== 8'h00) begin n_fail++; $display("FAIL pre_sp_eoi got %h want 00", ISR); end
  endtask

  task automatic test_aeoi();
    wr_icw(0, 8'h13);
    wr_icw(1, 8'h40);
    wr_icw(3, 8'h03);
    IRR = 8'h80; step();
    INTA_n = 1'b0; step();
    INTA_n = 1'b1; step();
    INTA_n = 1'b0; step();
    n_cmp++; if (Interrupt_Vector !== 8'h47) begin n_fail++; $display("FAIL aeoi_vec got %h want 47", Interrupt_Vector); end
    n_cmp++; if (ISR !== 8'h80) begin n_fail++; $display("FAIL aeoi_isr_held got %h want 80", ISR); end
    INTA_n = 1'b1; step();
    n_cmp++; if (ISR !== 8'h00) begin n_fail++; $display("FAIL aeoi_clear got %h want 00", ISR); end
    n_cmp++; if (Interrupt_Vector !== 8'h47) begin n_fail++; $display("FAIL aeoi_vec_hold got %h want 47", Interrupt_Vector); end
    IRR = 8'h00; step();
  endtask

  task automatic test_spurious();
    wr_icw(0, 8'h13);
    wr_icw(1, 8'h80);
    wr_icw(3, 8'h01);
    IRR = 8'h02; step();
    inta_cycle();
    n_cmp++; if (Interrupt_Vector !== 8'h81) begin n_fail++; $display("FAIL spur_pre_vec got %h want 81", Interrupt_Vector); end
    IRR = 8'h00; step();
    inta_cycle();
    n_cmp++; if (Interrupt_Vector !== 8'h87) begin n_fail++; $display("FAIL spur_vec got %h want 87", Interrupt_Vector); end
    n_cmp++; if (ISR !== 8'h02) begin n_fail++; $display("FAIL spur_isr got %h want 02", ISR); end
    wr_ocw(2, 8'h0B);
    n_cmp++; if (Read_command !== 2'b11) begin n_fail++; $display("FAIL ocw3_isr got %b want 11", Read_command); end
    wr_ocw(2, 8'h08);
    n_cmp++; if (Read_command !== 2'b11) begin n_fail++; $display("FAIL ocw3_hold got %b want 11", Read_command); end
  endtask

  task automatic test_icw1_abort();
    wr_ocw(0, 8'h10);
    IRR = 8'h01; step();
    INTA_n = 1'b0; step();
    INTA_n = 1'b1; step();
    IRR = 8'h00;
    wr_icw(0, 8'h13);
    n_cmp++; if (ISR !== 8'h00) begin n_fail++; $display("FAIL abort_isr got %h want 00", ISR); end
    n_cmp++; if (IMR !== 8'h00) begin n_fail++; $display("FAIL abort_imr got %h want 00", IMR); end
    n_cmp++; if (Read_command !== 2'b10) begin n_fail++; $display("FAIL abort_rdcmd got %b want 10", Read_command); end
    INTA_n = 1'b0; step();
    n_cmp++; if (IV_ready !== 1'b0) begin n_fail++; $display("FAIL abort_idle got %b want 0", IV_ready); end
    INTA_n = 1'b1; step();
  endtask

  task automatic test_rst_mid();
    wr_icw(0, 8'h13);
    wr_icw(1, 8'h40);
    wr_icw(3, 8'h01);
    wr_ocw(0, 8'h80);
    wr_ocw(2, 8'h0B);
    IRR = 8'h01; step();
    INTA_n = 1'b0; step();
    INTA_n = 1'b1; step();
    INTA_n = 1'b0; step();
    n_cmp++; if (IV_ready !== 1'b1) begin n_fail++; $display("FAIL rst_pre_ivr got %b want 1", IV_ready); end
    rst = 1'b1; step();
    n_cmp++; if (IV_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ivr got %b want 0", IV_ready); end
    n_cmp++; if (Interrupt_Vector !== 8'h00) begin n_fail++; $display("FAIL rst_vec got %h want 00", Interrupt_Vector); end
    n_cmp++; if (ISR !== 8'h00) begin n_fail++; $display("FAIL rst_isr got %h want 00", ISR); end
    n_cmp++; if (IMR !== 8'h00) begin n_fail++; $display("FAIL rst_imr got %h want 00", IMR); end
    n_cmp++; if (Read_command !== 2'b10) begin n_fail++; $display("FAIL rst_rdcmd got %b want 10", Read_command); end
    n_cmp++; if (INT !== 1'b0) begin n_fail++; $display("FAIL rst_int got %b want 0", INT); end
    rst = 1'b0; INTA_n = 1'b1; step(); step();
    n_cmp++; if (INT !== 1'b0) begin n_fail++; $display("FAIL rst_uninit_int got %b want 0", INT); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_basic();
    test_preempt();
    test_aeoi();
    test_spurious();
    test_icw1_abort();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
